// File: rtl/if_id_buffer_pkg.sv
// Shared MIPS pipeline constants and types for the fetch/decode boundary.
// The PC register uses the same reset vector and word width.
package if_id_buffer_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t MIPS_RESET_PC  = 32'h0000_3000;
  localparam word_t MIPS_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } entry_t;

  // Occupancy of the two-slot skid buffer
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_e;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle; the buffer sits on the slave modport.
interface if_id_buffer_if;
  import if_id_buffer_pkg::*;

  word_t if_pc;
  word_t if_instr;
  logic  if_valid;
  logic  if_ready;
  logic  flush;
  logic  id_ready;
  logic  id_valid;
  word_t id_pc;
  word_t id_instr;
  word_t id_pc8;
  logic  id_adel;

  modport master (
    output if_pc, if_instr, if_valid, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_pc8, id_adel
  );

  modport slave (
    input  if_pc, if_instr, if_valid, flush, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_pc8, id_adel
  );

endinterface

// File: rtl/if_id_buffer.sv
// Two-entry FIFO between fetch and decode; decode outputs come straight from
// the head slot registers, so nothing from the fetch side reaches them combinationally.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter word_t RESET_PC  = MIPS_RESET_PC,
  parameter word_t NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  if_id_buffer_if.slave        bus
);

  count_e count_q, count_d;
  entry_t slot0_q, slot0_d;
  entry_t slot1_q, slot1_d;

  logic   push;
  logic   pop;
  entry_t incoming;

  assign incoming = '{pc: bus.if_pc, instr: bus.if_instr};

  assign bus.if_ready = (count_q != CNT_FULL);
  assign bus.id_valid = (count_q != CNT_EMPTY);

  assign push = bus.if_valid && bus.if_ready && !bus.flush;
  assign pop  = bus.id_valid && bus.id_ready && !bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CNT_EMPTY;
      slot0_q <= '{pc: RESET_PC, instr: NOP_INSTR};
      slot1_q <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // flush only clears occupancy; slot contents are deliberately retained
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (bus.flush) begin
      count_d = CNT_EMPTY;
    end else begin
      unique case (count_q)
        CNT_EMPTY: begin
          if (push) begin
            slot0_d = incoming;
            count_d = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            slot0_d = incoming;
          end else if (push) begin
            slot1_d = incoming;
            count_d = CNT_FULL;
          end else if (pop) begin
            count_d = CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            slot0_d = slot1_q;
            count_d = CNT_ONE;
          end
        end
        default: count_d = CNT_EMPTY;
      endcase
    end
  end

  assign bus.id_pc    = slot0_q.pc;
  assign bus.id_instr = bus.id_valid ? slot0_q.instr : NOP_INSTR;
  assign bus.id_pc8   = slot0_q.pc + 32'd8;
  assign bus.id_adel  = bus.id_valid && (slot0_q.pc[1:0] != 2'b00);

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed checks of the IF/ID buffer: reset, streaming, stall, flush,
// link/alignment and asynchronous reset.
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  logic clk;
  logic reset;
  int unsigned n_vec;
  int unsigned n_bad;

  if_id_buffer_if bus();

  if_id_buffer #(
    .RESET_PC  (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    drive(1'b1, 32'h0000_3000, 32'h1111_0000);

    // reset held with a fetch on offer
    repeat (3) tick();
    expect_eq("rst_valid", 32'(bus.id_valid), 32'd0);
    expect_eq("rst_ready", 32'(bus.if_ready), 32'd1);
    expect_eq("rst_pc",    bus.id_pc,         32'h0000_3000);
    expect_eq("rst_instr", bus.id_instr,      32'h0000_0000);
    expect_eq("rst_pc8",   bus.id_pc8,        32'h0000_3008);
    expect_eq("rst_adel",  32'(bus.id_adel),  32'd0);
    drive(1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    expect_eq("post_rst_valid", 32'(bus.id_valid), 32'd0);

    // streaming with decode always ready
    bus.id_ready = 1'b1;
    drive(1'b1, 32'h0000_3000, 32'hA000_0000); tick();
    expect_eq("str0_valid", 32'(bus.id_valid), 32'd1);
    expect_eq("str0_pc",    bus.id_pc,         32'h0000_3000);
    expect_eq("str0_instr", bus.id_instr,      32'hA000_0000);
    drive(1'b1, 32'h0000_3004, 32'hA000_0004); tick();
    expect_eq("str1_pc",    bus.id_pc,         32'h0000_3004);
    expect_eq("str1_instr", bus.id_instr,      32'hA000_0004);
    expect_eq("str1_ready", 32'(bus.if_ready), 32'd1);
    drive(1'b1, 32'h0000_3008, 32'hA000_0008); tick();
    expect_eq("str2_pc",    bus.id_pc,         32'h0000_3008);
    expect_eq("str2_ready", 32'(bus.if_ready), 32'd1);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_eq("str_drain_valid", 32'(bus.id_valid), 32'd0);
    expect_eq("str_drain_instr", bus.id_instr,      32'h0000_0000);
    expect_eq("str_drain_pc",    bus.id_pc,         32'h0000_3008);

    // stall: decode not ready while three fetches are offered
    bus.id_ready = 1'b0;
    drive(1'b1, 32'h0000_3000, 32'hB000_0000); tick();
    expect_eq("stl0_pc",    bus.id_pc,         32'h0000_3000);
    expect_eq("stl0_ready", 32'(bus.if_ready), 32'd1);
    drive(1'b1, 32'h0000_3004, 32'hB000_0004); tick();
    expect_eq("stl1_pc",    bus.id_pc,         32'h0000_3000);
    expect_eq("stl1_ready", 32'(bus.if_ready), 32'd0);
    drive(1'b1, 32'h0000_3008, 32'hB000_0008); tick();
    expect_eq("stl2_pc",    bus.id_pc,         32'h0000_3000);
    expect_eq("stl2_instr", bus.id_instr,      32'hB000_0000);
    expect_eq("stl2_ready", 32'(bus.if_ready), 32'd0);
    bus.id_ready = 1'b1; tick();
    expect_eq("rel0_pc",    bus.id_pc,         32'h0000_3004);
    expect_eq("rel0_instr", bus.id_instr,      32'hB000_0004);
    expect_eq("rel0_ready", 32'(bus.if_ready), 32'd1);
    tick();
    expect_eq("rel1_pc",    bus.id_pc,         32'h0000_3008);
    expect_eq("rel1_instr", bus.id_instr,      32'hB000_0008);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_eq("rel_drain_valid", 32'(bus.id_valid), 32'd0);

    // flush at full with a concurrent fetch
    bus.id_ready = 1'b0;
    drive(1'b1, 32'h0000_3000, 32'hC000_0000); tick();
    drive(1'b1, 32'h0000_3004, 32'hC000_0004); tick();
    expect_eq("fl_pre_ready", 32'(bus.if_ready), 32'd0);
    bus.flush = 1'b1;
    drive(1'b1, 32'h0000_300C, 32'hC000_000C); tick();
    expect_eq("fl_valid", 32'(bus.id_valid), 32'd0);
    expect_eq("fl_ready", 32'(bus.if_ready), 32'd1);
    expect_eq("fl_instr", bus.id_instr,      32'h0000_0000);
    expect_eq("fl_pc",    bus.id_pc,         32'h0000_3000);
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_eq("fl_after_valid", 32'(bus.id_valid), 32'd0);

    // link address and misaligned fetch
    bus.id_ready = 1'b1;
    drive(1'b1, 32'h0000_3002, 32'hD000_0000); tick();
    expect_eq("lk0_adel", 32'(bus.id_adel), 32'd1);
    expect_eq("lk0_pc8",  bus.id_pc8,       32'h0000_300A);
    drive(1'b1, 32'hFFFF_FFFC, 32'hD000_0004); tick();
    expect_eq("lk1_pc8",  bus.id_pc8,       32'h0000_0004);
    expect_eq("lk1_adel", 32'(bus.id_adel), 32'd0);
    drive(1'b1, 32'h0000_3001, 32'hD000_0008); tick();
    expect_eq("lk2_adel", 32'(bus.id_adel), 32'd1);
    drive(1'b0, 32'h0, 32'h0); tick();
    expect_eq("lk_empty_adel", 32'(bus.id_adel), 32'd0);

    // asynchronous reset between edges while full
    bus.id_ready = 1'b0;
    drive(1'b1, 32'h0000_3100, 32'hE000_0000); tick();
    drive(1'b1, 32'h0000_3104, 32'hE000_0004); tick();
    drive(1'b0, 32'h0, 32'h0);
    expect_eq("ar_pre_pc",    bus.id_pc,         32'h0000_3100);
    expect_eq("ar_pre_ready", 32'(bus.if_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    expect_eq("ar_valid", 32'(bus.id_valid), 32'd0);
    expect_eq("ar_ready", 32'(bus.if_ready), 32'd1);
    expect_eq("ar_pc",    bus.id_pc,         32'h0000_3000);
    expect_eq("ar_instr", bus.id_instr,      32'h0000_0000);
    expect_eq("ar_pc8",   bus.id_pc8,        32'h0000_3008);
    tick();
    reset = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    expect_eq("ar_after_valid", 32'(bus.id_valid), 32'd0);
    expect_eq("ar_after_pc",    bus.id_pc,         32'h0000_3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
